// File: rtl/cbus_arbiter.sv
// ============================================================================
// Module   : cbus_arbiter
// Purpose  : Burst-granular arbiter sharing one cache bus among NUM_REQ masters.
//            Optional round-robin policy when CBUS_ARBITER_RR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cbus_pkg;
    localparam logic [3:0] c_MLEN1  = 4'd0;
    localparam logic [3:0] c_MLEN4  = 4'd3;
    localparam logic [3:0] c_MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  len;
        logic [3:0]  strobe;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int CNT_BITS = 5,
    localparam int OW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  cbus_req_t         ireqs  [NUM_REQ],
    output cbus_resp_t        oresps [NUM_REQ],
    output cbus_req_t         oreq,
    input  cbus_resp_t        iresp,
    output logic              busy_o,
    output logic [OW-1:0]     owner_o,
    output logic              proto_err_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               r_state;
    logic [OW-1:0]        r_owner;
    logic [CNT_BITS-1:0]  r_cnt;
    logic                 r_err;

    logic                 w_any;
    logic [OW-1:0]        w_winner;
    logic                 w_fire;
    logic                 w_len_bad;
    cbus_req_t            w_oreq;

    always_comb begin
        w_oreq = '0;
        if (r_state == BUSY) begin
            w_oreq = ireqs[r_owner];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            oresps[i] = '0;
        end
        if (r_state == BUSY) begin
            oresps[r_owner] = iresp;
        end
    end

`ifdef CBUS_ARBITER_RR_EN
    logic [OW-1:0] r_last_grant;

    // Search begins one past the previous grant and wraps.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_any && ireqs[(int'(r_last_grant) + k) % NUM_REQ].valid) begin
                w_any    = 1'b1;
                w_winner = OW'((int'(r_last_grant) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= OW'(NUM_REQ - 1);
        end else if (r_state == IDLE && w_any) begin
            r_last_grant <= w_winner;
        end
    end
`else
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (ireqs[i].valid) begin
                w_any    = 1'b1;
                w_winner = OW'(i);
            end
        end
    end
`endif

    assign w_fire    = w_oreq.valid & iresp.ready;
    // Count holds completed beats, so `last` is legal only when count == len.
    assign w_len_bad = (r_cnt != CNT_BITS'(w_oreq.len));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (iresp.ready) begin
                        r_err <= 1'b1;
                    end
                    if (w_any) begin
                        r_state <= BUSY;
                        r_owner <= w_winner;
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (w_fire && (r_cnt != '1)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_fire && iresp.last && w_len_bad) begin
                        r_err <= 1'b1;
                    end
                    if (!w_oreq.valid || (w_fire && iresp.last)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oreq        = w_oreq;
    assign busy_o      = (r_state == BUSY);
    assign owner_o     = r_owner;
    assign proto_err_o = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
// ============================================================================
// Module   : tb_cbus_arbiter
// Purpose  : Self-checking bench for cbus_arbiter (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam logic [31:0] c_A0 = 32'h1000_0000;
    localparam logic [31:0] c_A1 = 32'h8000_0040;

    logic       clk;
    logic       resetn;
    cbus_req_t  ireqs  [2];
    cbus_resp_t oresps [2];
    cbus_req_t  oreq;
    cbus_resp_t iresp;
    logic       busy_o;
    logic [0:0] owner_o;
    logic       proto_err_o;

    int n_pass;
    int n_total;

    logic        m1_write;
    logic [31:0] m1_data;

    logic [31:0] sb_q  [$];
    int          own_q [$];

    cbus_arbiter #(.NUM_REQ(2), .CNT_BITS(5)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ireqs       (ireqs),
        .oresps      (oresps),
        .oreq        (oreq),
        .iresp       (iresp),
        .busy_o      (busy_o),
        .owner_o     (owner_o),
        .proto_err_o (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [3:0] l0, input logic v1, input logic [3:0] l1,
                         input logic rdy, input logic lst, input logic [31:0] rd);
        ireqs[0]          = '0;
        ireqs[0].valid    = v0;
        ireqs[0].addr     = c_A0;
        ireqs[0].size     = 3'd2;
        ireqs[0].len      = l0;
        ireqs[1]          = '0;
        ireqs[1].valid    = v1;
        ireqs[1].is_write = m1_write;
        ireqs[1].addr     = c_A1;
        ireqs[1].size     = 3'd2;
        ireqs[1].len      = l1;
        ireqs[1].strobe   = m1_write ? 4'hF : 4'h0;
        ireqs[1].data     = m1_data;
        iresp.ready       = rdy;
        iresp.last        = lst;
        iresp.data        = rd;
    endtask

    typedef struct {
        logic        v0;
        logic [3:0]  l0;
        logic        v1;
        logic [3:0]  l1;
        logic        rdy;
        logic        lst;
        logic [31:0] rd;
        logic        e_busy;
        logic        e_own;
        logic        e_ov;
        logic        e_err;
    } vec_t;

    vec_t tv [14];

    logic [31:0] wb [4];

    initial begin
        n_pass   = 0;
        n_total  = 0;
        m1_write = 1'b0;
        m1_data  = '0;
        resetn   = 1'b0;
        drive(0, 4'd0, 0, 4'd0, 0, 0, 32'h0);

        // Refill by master 1, then simultaneous requests from both masters.
        tv[0]  = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 32'h22, 1'b1, 1'b1, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 32'h33, 1'b1, 1'b1, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 4'd3, 1'b1, 4'd0, 1'b1, 1'b0, 32'hA1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{1'b1, 4'd3, 1'b1, 4'd0, 1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 4'd3, 1'b1, 4'd0, 1'b1, 1'b0, 32'hA3, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[10] = '{1'b1, 4'd3, 1'b1, 4'd0, 1'b1, 1'b1, 32'hA4, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[11] = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[12] = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 32'hB1, 1'b1, 1'b1, 1'b1, 1'b0};
        tv[13] = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        wb[0] = 32'hDEAD_0001;
        wb[1] = 32'hBEEF_0002;
        wb[2] = 32'hCAFE_0003;
        wb[3] = 32'hF00D_0004;

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_busy",  {31'd0, busy_o}, 32'd0);
        chk("rst_owner", {31'd0, owner_o}, 32'd0);
        chk("rst_err",   {31'd0, proto_err_o}, 32'd0);
        chk("rst_oreq",  {31'd0, |oreq}, 32'd0);
        chk("rst_oresp", {31'd0, (|oresps[0]) | (|oresps[1])}, 32'd0);
        #2 resetn = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            drive(tv[i].v0, tv[i].l0, tv[i].v1, tv[i].l1, tv[i].rdy, tv[i].lst, tv[i].rd);
            if (tv[i].rdy && tv[i].e_busy) sb_q.push_back(tv[i].rd);
            @(negedge clk);
            chk($sformatf("v%0d_busy", i), {31'd0, busy_o}, {31'd0, tv[i].e_busy});
            chk($sformatf("v%0d_ovalid", i), {31'd0, oreq.valid}, {31'd0, tv[i].e_ov});
            chk($sformatf("v%0d_err", i), {31'd0, proto_err_o}, {31'd0, tv[i].e_err});
            if (tv[i].e_busy) begin
                chk($sformatf("v%0d_owner", i), {31'd0, owner_o}, {31'd0, tv[i].e_own});
                chk($sformatf("v%0d_addr", i), oreq.addr, tv[i].e_own ? c_A1 : c_A0);
            end
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("v%0d_rdy%0d", i, m), {31'd0, oresps[m].ready},
                    {31'd0, tv[i].e_busy && tv[i].rdy && (int'(tv[i].e_own) == m)});
                if (oresps[m].ready) begin
                    if (sb_q.size() == 0) begin
                        chk($sformatf("v%0d_sb_underflow", i), 32'(sb_q.size()), 32'd1);
                    end else begin
                        chk($sformatf("v%0d_rdata%0d", i, m), oresps[m].data, sb_q.pop_front());
                    end
                end
            end
            tick();
        end
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        // Write-back with ready every other cycle; master 0 asks mid-burst
        begin
            int beat;
            logic rdy;
            m1_write = 1'b1;
            m1_data  = wb[0];
            drive(0, 4'd0, 1, 4'd3, 0, 0, 32'h0);
            @(negedge clk);
            chk("wb_idle", {31'd0, busy_o}, 32'd0);
            tick();
            beat = 0;
            for (int k = 0; k < 8; k++) begin
                rdy     = (k % 2) == 1;
                m1_data = wb[beat];
                drive(k >= 1, 4'd0, 1, 4'd3, rdy, rdy && (beat == 3), 32'h0);
                @(negedge clk);
                chk($sformatf("wb%0d_busy", k), {31'd0, busy_o}, 32'd1);
                chk($sformatf("wb%0d_owner", k), {31'd0, owner_o}, 32'd1);
                chk($sformatf("wb%0d_data", k), oreq.data, wb[beat]);
                chk($sformatf("wb%0d_strb", k), {28'd0, oreq.strobe}, 32'hF);
                chk($sformatf("wb%0d_wr", k), {31'd0, oreq.is_write}, 32'd1);
                tick();
                if (rdy) beat++;
            end
            m1_write = 1'b0;
            m1_data  = '0;
            drive(1, 4'd0, 0, 4'd0, 0, 0, 32'h0);
            @(negedge clk);
            chk("wb_rel_busy", {31'd0, busy_o}, 32'd0);
            chk("wb_rel_ov", {31'd0, oreq.valid}, 32'd0);
            tick();
            drive(1, 4'd0, 0, 4'd0, 1, 1, 32'h55);
            @(negedge clk);
            chk("wb_m0_busy", {31'd0, busy_o}, 32'd1);
            chk("wb_m0_owner", {31'd0, owner_o}, 32'd0);
            tick();
            drive(0, 4'd0, 0, 4'd0, 0, 0, 32'h0);
            tick();
        end

        // Owner abort
        drive(1, 4'd3, 0, 4'd0, 0, 0, 32'h0);
        tick();
        drive(1, 4'd3, 0, 4'd0, 1, 0, 32'h5);
        @(negedge clk);
        chk("ab_busy", {31'd0, busy_o}, 32'd1);
        tick();
        drive(0, 4'd3, 0, 4'd0, 0, 0, 32'h0);
        @(negedge clk);
        chk("ab_ov_drop", {31'd0, oreq.valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("ab_idle", {31'd0, busy_o}, 32'd0);
        chk("ab_noerr", {31'd0, proto_err_o}, 32'd0);
        tick();

        // Single-beat grant to master 1 so the next grant order starts at 0
        drive(0, 4'd0, 1, 4'd0, 0, 0, 32'h0);
        tick();
        drive(0, 4'd0, 1, 4'd0, 1, 1, 32'h66);
        @(negedge clk);
        chk("one_owner", {31'd0, owner_o}, 32'd1);
        chk("one_data", oresps[1].data, 32'h66);
        tick();
        drive(0, 4'd0, 0, 4'd0, 0, 0, 32'h0);
        tick();

        // Both masters held valid for 4 bursts
        for (int b = 0; b < 4; b++) begin
            drive(1, 4'd0, 1, 4'd0, 0, 0, 32'h0);
            @(negedge clk);
            chk($sformatf("rr%0d_gap", b), {31'd0, busy_o}, 32'd0);
            tick();
            drive(1, 4'd0, 1, 4'd0, 1, 1, 32'h0);
`ifdef CBUS_ARBITER_RR_EN
            own_q.push_back(b % 2);
`else
            own_q.push_back(0);
`endif
            @(negedge clk);
            chk($sformatf("rr%0d_busy", b), {31'd0, busy_o}, 32'd1);
            if (busy_o) chk($sformatf("rr%0d_owner", b), {31'd0, owner_o}, 32'(own_q.pop_front()));
            tick();
        end
        drive(0, 4'd0, 0, 4'd0, 0, 0, 32'h0);
        tick();

        // Last on beat 2 of an MLEN4 read
        drive(0, 4'd0, 1, c_MLEN4, 0, 0, 32'h0);
        tick();
        drive(0, 4'd0, 1, c_MLEN4, 1, 0, 32'h1);
        tick();
        drive(0, 4'd0, 1, c_MLEN4, 1, 1, 32'h2);
        @(negedge clk);
        chk("pe_before", {31'd0, proto_err_o}, 32'd0);
        tick();
        drive(0, 4'd0, 0, 4'd0, 0, 0, 32'h0);
        @(negedge clk);
        chk("pe_set", {31'd0, proto_err_o}, 32'd1);
        chk("pe_released", {31'd0, busy_o}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        chk("pe_held", {31'd0, proto_err_o}, 32'd1);
        tick();

        // Asynchronous reset in the middle of a burst
        drive(1, 4'd3, 0, 4'd0, 0, 0, 32'h0);
        tick();
        drive(1, 4'd3, 0, 4'd0, 1, 0, 32'h77);
        @(negedge clk);
        chk("ar_busy", {31'd0, busy_o}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("ar_busy0", {31'd0, busy_o}, 32'd0);
        chk("ar_err0", {31'd0, proto_err_o}, 32'd0);
        chk("ar_oreq0", {31'd0, |oreq}, 32'd0);
        chk("ar_oresp0", {31'd0, (|oresps[0]) | (|oresps[1])}, 32'd0);
        drive(0, 4'd0, 0, 4'd0, 0, 0, 32'h0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Ready while idle
        drive(0, 4'd0, 0, 4'd0, 1, 0, 32'h0);
        @(negedge clk);
        chk("ir_before", {31'd0, proto_err_o}, 32'd0);
        tick();
        drive(0, 4'd0, 0, 4'd0, 0, 0, 32'h0);
        @(negedge clk);
        chk("ir_set", {31'd0, proto_err_o}, 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
